// File: rtl/alu_arbiter_if.sv
// Requester-side bundle of the shared-ALU arbiter: packed per-requester request lanes
// plus the broadcast response bus with its one-hot response strobe.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_opr1;
  logic [NUM_REQ*32-1:0] req_opr2;
  logic [NUM_REQ*4-1:0]  req_ctrl;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [31:0]           resp_result;
  logic                  resp_overflow;
  logic                  resp_zero;
  logic                  resp_negative;

  modport master (
    output req_valid, req_opr1, req_opr2, req_ctrl,
    input  req_ready, resp_valid, resp_result, resp_overflow, resp_zero, resp_negative
  );

  modport slave (
    input  req_valid, req_opr1, req_opr2, req_ctrl,
    output req_ready, resp_valid, resp_result, resp_overflow, resp_zero, resp_negative
  );
endinterface

// File: rtl/alu_arbiter.sv
// Time-shares one combinational 32-bit ALU between NUM_REQ requesters: accept, one EXEC
// cycle driving the ALU from registered operands, then a one-cycle response pulse.
module alu_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus,
  output logic          busy,
  output logic [31:0]   alu_opr1,
  output logic [31:0]   alu_opr2,
  output logic [3:0]    alu_ctrl,
  input  logic [31:0]   alu_result,
  input  logic          alu_overflow,
  input  logic          alu_zero,
  input  logic          alu_negative
);
  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [PW-1:0]        ptr;
  logic [PW-1:0]        winner;
  logic [PW-1:0]        owner;
  logic                 found;
  logic                 accepting;
  logic                 grant;
  logic [NUM_REQ-1:0]   ready_vec;
  logic [NUM_REQ-1:0]   resp_vec;
  logic [31:0]          opr1_q;
  logic [31:0]          opr2_q;
  logic [3:0]           ctrl_q;
  logic [31:0]          result_q;
  logic                 overflow_q;
  logic                 zero_q;
  logic                 negative_q;

  // Rotating search starting at the priority pointer; the first valid requester wins.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  assign accepting = (state == IDLE) || (state == RESP);
  assign grant     = accepting && found;

  always_comb begin
    ready_vec = '0;
    if (grant) begin
      ready_vec[winner] = 1'b1;
    end
  end

  always_comb begin
    resp_vec = '0;
    if (state == RESP) begin
      resp_vec[owner] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = grant ? EXEC : IDLE;
      EXEC:    state_next = RESP;
      RESP:    state_next = grant ? EXEC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture and priority pointer; both only move on an accepting edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr    <= '0;
      owner  <= '0;
      opr1_q <= '0;
      opr2_q <= '0;
      ctrl_q <= '0;
    end else if (grant) begin
      owner  <= winner;
      opr1_q <= bus.req_opr1[32*int'(winner) +: 32];
      opr2_q <= bus.req_opr2[32*int'(winner) +: 32];
      ctrl_q <= bus.req_ctrl[4*int'(winner) +: 4];
      if (ROUND_ROBIN) begin
        ptr <= (winner == PW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end else begin
        ptr <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q   <= '0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else if (state == EXEC) begin
      result_q   <= alu_result;
      overflow_q <= alu_overflow;
      zero_q     <= alu_zero;
      negative_q <= alu_negative;
    end
  end

  assign bus.req_ready     = ready_vec;
  assign bus.resp_valid    = resp_vec;
  assign bus.resp_result   = result_q;
  assign bus.resp_overflow = overflow_q;
  assign bus.resp_zero     = zero_q;
  assign bus.resp_negative = negative_q;

  assign busy     = (state == EXEC);
  assign alu_opr1 = opr1_q;
  assign alu_opr2 = opr2_q;
  assign alu_ctrl = ctrl_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin and a fixed-priority instance, each driving
// a small behavioural ALU, checked against hand-computed responses.
module tb_alu_arbiter;
  logic clk;
  logic reset;
  int   testCount;
  int   failCount;

  alu_arbiter_if #(.NUM_REQ(3)) rr_bus ();
  alu_arbiter_if #(.NUM_REQ(3)) fp_bus ();

  logic        rr_busy, fp_busy;
  logic [31:0] rr_opr1, rr_opr2, fp_opr1, fp_opr2;
  logic [3:0]  rr_ctrl, fp_ctrl;
  logic [31:0] rr_res, fp_res;
  logic        rr_ovf, fp_ovf;

  // Behavioural ALU: returns {overflow, result}
  function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] c);
    logic [31:0] r;
    logic        v;
    r = '0;
    v = 1'b0;
    case (c)
      4'b0000: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'b0001: r = a & b;
      4'b0010: r = a | b;
      4'b0011: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'b1010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1011: r = (a < b) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    return {v, r};
  endfunction

  assign {rr_ovf, rr_res} = alu_model(rr_opr1, rr_opr2, rr_ctrl);
  assign {fp_ovf, fp_res} = alu_model(fp_opr1, fp_opr2, fp_ctrl);

  alu_arbiter #(.NUM_REQ(3), .ROUND_ROBIN(1'b1)) u_rr (
    .clk(clk), .reset(reset), .bus(rr_bus.slave), .busy(rr_busy),
    .alu_opr1(rr_opr1), .alu_opr2(rr_opr2), .alu_ctrl(rr_ctrl),
    .alu_result(rr_res), .alu_overflow(rr_ovf),
    .alu_zero(rr_res == 32'd0), .alu_negative(rr_res[31])
  );

  alu_arbiter #(.NUM_REQ(3), .ROUND_ROBIN(1'b0)) u_fp (
    .clk(clk), .reset(reset), .bus(fp_bus.slave), .busy(fp_busy),
    .alu_opr1(fp_opr1), .alu_opr2(fp_opr2), .alu_ctrl(fp_ctrl),
    .alu_result(fp_res), .alu_overflow(fp_ovf),
    .alu_zero(fp_res == 32'd0), .alu_negative(fp_res[31])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] c);
    rr_bus.req_valid[idx]          = 1'b1;
    rr_bus.req_opr1[32*idx +: 32]  = a;
    rr_bus.req_opr2[32*idx +: 32]  = b;
    rr_bus.req_ctrl[4*idx +: 4]    = c;
  endtask

  task automatic checkResp(input string tag, input logic [2:0] vld, input logic [31:0] res,
                           input logic ovf, input logic zero, input logic neg);
    checkOutput({tag, "_valid"}, 32'(rr_bus.resp_valid), 32'(vld));
    checkOutput({tag, "_result"}, rr_bus.resp_result, res);
    checkOutput({tag, "_ovf"}, 32'(rr_bus.resp_overflow), 32'(ovf));
    checkOutput({tag, "_zero"}, 32'(rr_bus.resp_zero), 32'(zero));
    checkOutput({tag, "_neg"}, 32'(rr_bus.resp_negative), 32'(neg));
  endtask

  // Grant/response table for three always-valid requesters, valid dropped from cycle 9.
  logic [2:0]  rr_exp_ready [11] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000,
                                     3'b001, 3'b000, 3'b010, 3'b000, 3'b000};
  logic [2:0]  rr_exp_resp  [11] = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b010, 3'b000,
                                     3'b100, 3'b000, 3'b001, 3'b000, 3'b010};
  logic [31:0] rr_exp_res   [11] = '{32'd0, 32'd0, 32'd10, 32'd0, 32'd21, 32'd0,
                                     32'd32, 32'd0, 32'd10, 32'd0, 32'd21};

  initial begin
    testCount = 0;
    failCount = 0;
    reset = 1'b1;
    rr_bus.req_valid = '0; rr_bus.req_opr1 = '0; rr_bus.req_opr2 = '0; rr_bus.req_ctrl = '0;
    fp_bus.req_valid = '0; fp_bus.req_opr1 = '0; fp_bus.req_opr2 = '0; fp_bus.req_ctrl = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 32'(rr_bus.req_ready), 32'd0);
    checkOutput("rst_resp_valid", 32'(rr_bus.resp_valid), 32'd0);
    checkOutput("rst_result", rr_bus.resp_result, 32'd0);
    checkOutput("rst_busy", 32'(rr_busy), 32'd0);
    checkOutput("rst_alu_opr1", rr_opr1, 32'd0);
    reset = 1'b0;

    // 5 + 7 from requester 0
    applyStimulus(0, 32'd5, 32'd7, 4'b0000);
    #1 checkOutput("add_ready", 32'(rr_bus.req_ready), 32'b001);
    @(negedge clk);
    rr_bus.req_valid = '0;
    #1;
    checkOutput("add_busy", 32'(rr_busy), 32'd1);
    checkOutput("add_alu_opr1", rr_opr1, 32'd5);
    checkOutput("add_alu_opr2", rr_opr2, 32'd7);
    checkOutput("add_exec_resp", 32'(rr_bus.resp_valid), 32'd0);
    @(negedge clk);
    checkResp("add", 3'b001, 32'd12, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("add_pulse_end", 32'(rr_bus.resp_valid), 32'd0);
    checkOutput("add_hold", rr_bus.resp_result, 32'd12);

    // Signed overflow from requester 1 (pointer now at 1)
    applyStimulus(1, 32'h7FFF_FFFF, 32'd1, 4'b0000);
    #1 checkOutput("ovf_ready", 32'(rr_bus.req_ready), 32'b010);
    @(negedge clk);
    rr_bus.req_valid = '0;
    @(negedge clk);
    checkResp("ovf", 3'b010, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(1, 32'd3, 32'd3, 4'b0011);
    #1 checkOutput("sub_ready", 32'(rr_bus.req_ready), 32'b010);
    @(negedge clk);
    rr_bus.req_valid = '0;
    @(negedge clk);
    checkResp("sub", 3'b010, 32'd0, 1'b0, 1'b1, 1'b0);

    // Round-robin rotation with all requesters valid, starting from a reset pointer
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(i, 32'(10 * (i + 1)), 32'(i), 4'b0000);
    end
    for (int c = 0; c < 11; c++) begin
      if (c == 9) rr_bus.req_valid = '0;
      #1;
      checkOutput($sformatf("rr_ready_c%0d", c), 32'(rr_bus.req_ready), 32'(rr_exp_ready[c]));
      checkOutput($sformatf("rr_resp_c%0d", c), 32'(rr_bus.resp_valid), 32'(rr_exp_resp[c]));
      if (rr_exp_resp[c] != 3'b000) begin
        checkOutput($sformatf("rr_result_c%0d", c), rr_bus.resp_result, rr_exp_res[c]);
      end
      @(negedge clk);
    end

    // Fixed priority: requester 2 starves while requester 0 stays valid
    fp_bus.req_valid = 3'b101;
    fp_bus.req_opr1  = {32'd4, 32'd0, 32'd1};
    fp_bus.req_opr2  = {32'd4, 32'd0, 32'd1};
    fp_bus.req_ctrl  = '0;
    for (int c = 0; c < 6; c++) begin
      #1;
      checkOutput($sformatf("fp_ready_c%0d", c), 32'(fp_bus.req_ready),
                  (c % 2 == 0) ? 32'b001 : 32'b000);
      if (c == 2) checkOutput("fp_req0_result", fp_bus.resp_result, 32'd2);
      @(negedge clk);
    end
    fp_bus.req_valid = 3'b100;
    #1 checkOutput("fp_req2_ready", 32'(fp_bus.req_ready), 32'b100);
    @(negedge clk);
    fp_bus.req_valid = '0;
    @(negedge clk);
    checkOutput("fp_req2_resp", 32'(fp_bus.resp_valid), 32'b100);
    checkOutput("fp_req2_result", fp_bus.resp_result, 32'd8);
    @(negedge clk);

    // Reset during EXEC discards the operation
    applyStimulus(0, 32'd9, 32'd1, 4'b0000);
    #1 checkOutput("rst_exec_ready", 32'(rr_bus.req_ready), 32'b001);
    @(negedge clk);
    rr_bus.req_valid = '0;
    #1 checkOutput("rst_exec_busy", 32'(rr_busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_exec_no_resp", 32'(rr_bus.resp_valid), 32'd0);
    checkOutput("rst_exec_result", rr_bus.resp_result, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_exec_no_resp2", 32'(rr_bus.resp_valid), 32'd0);
    applyStimulus(0, 32'd2, 32'd2, 4'b0000);
    #1 checkOutput("post_rst_ready", 32'(rr_bus.req_ready), 32'b001);
    @(negedge clk);
    rr_bus.req_valid = '0;
    @(negedge clk);
    checkResp("post_rst", 3'b001, 32'd4, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // SLT then back-to-back SLTU accepted in the RESP cycle
    applyStimulus(0, 32'hFFFF_FFFF, 32'd1, 4'b1010);
    #1 checkOutput("slt_ready", 32'(rr_bus.req_ready), 32'b001);
    @(negedge clk);
    rr_bus.req_valid = '0;
    #1 checkOutput("slt_alu_ctrl", 32'(rr_ctrl), 32'hA);
    @(negedge clk);
    checkResp("slt", 3'b001, 32'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 32'hFFFF_FFFF, 32'd1, 4'b1011);
    #1 checkOutput("sltu_ready_in_resp", 32'(rr_bus.req_ready), 32'b001);
    @(negedge clk);
    rr_bus.req_valid = '0;
    #1;
    checkOutput("sltu_exec_resp", 32'(rr_bus.resp_valid), 32'd0);
    checkOutput("sltu_alu_ctrl", 32'(rr_ctrl), 32'hB);
    @(negedge clk);
    checkResp("sltu", 3'b001, 32'd0, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
